// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: FSM encodings,
// a constant clog2 helper and the hardwired-zero register index.
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

    // Constant-evaluable so it can size ports in parameter-dependent headers.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Soft-clear sequencer: walks ptr from 1 to DEPTH-1, zeroing one entry per
// cycle while busy is high. Register 0 is never stored, so the sweep skips it.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clock_reg,
    input  logic                      reset,
    input  logic                      clear_req,
    output logic                      busy,
    output logic                      clr_en,
    output logic [clog2(DEPTH)-1:0]   clr_addr
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        ptr   <= AW'(1);
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // clear_req is deliberately ignored here; a held request
                    // restarts only after one IDLE cycle.
                    if (ptr == LAST_ADDR) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en   = (state == ST_CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_param_2r1w.sv
// 2-read/1-write flop-based register file, register 0 hardwired to zero,
// registered reads with write-first bypass and a soft-clear sweep.
module regfile_param_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clock_reg,
    input  logic                      reset,
    input  logic                      write_enable,
    input  logic [clog2(DEPTH)-1:0]   write_address,
    input  logic [WIDTH-1:0]          write_data,
    input  logic [clog2(DEPTH)-1:0]   register_address1,
    input  logic [clog2(DEPTH)-1:0]   register_address2,
    input  logic                      clear_req,
    output logic [WIDTH-1:0]          register_data1,
    output logic [WIDTH-1:0]          register_data2,
    output logic                      busy
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             clr_en;
    logic [AW-1:0]    clr_addr;
    logic             wr_ok;
    logic [WIDTH-1:0] rd_next1;
    logic [WIDTH-1:0] rd_next2;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clock_reg (clock_reg),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    // Writes are only honoured in IDLE; a write during the sweep is dropped.
    assign wr_ok = write_enable && !clr_en && (write_address != ZERO_ADDR);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rd_next1 = '0;
        rd_next2 = '0;
        if (!clr_en) begin
            if (register_address1 != ZERO_ADDR) begin
                rd_next1 = (wr_ok && (write_address == register_address1))
                           ? write_data : mem[register_address1];
            end
            if (register_address2 != ZERO_ADDR) begin
                rd_next2 = (wr_ok && (write_address == register_address2))
                           ? write_data : mem[register_address2];
            end
        end
    end

    // NOTE: the array is reset entry by entry, which rules out RAM macro
    // inference; that is intended, storage is plain flops.
    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            register_data1 <= '0;
            register_data2 <= '0;
        end else begin
            if (clr_en) begin
                mem[clr_addr] <= '0;
            end else if (wr_ok) begin
                mem[write_address] <= write_data;
            end
            register_data1 <= rd_next1;
            register_data2 <= rd_next2;
        end
    end

endmodule

// File: tb/tb_regfile_param_2r1w.sv
// Scoreboard bench for regfile_param_2r1w (WIDTH=8, DEPTH=16): stimulus
// queues hand-computed expectations, a negedge monitor pops and compares.
module tb_regfile_param_2r1w;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int K_RD1  = 0;
    localparam int K_RD2  = 1;
    localparam int K_BUSY = 2;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic             clock_reg = 1'b0;
    logic             reset;
    logic             write_enable;
    logic [AW-1:0]    write_address;
    logic [WIDTH-1:0] write_data;
    logic [AW-1:0]    register_address1;
    logic [AW-1:0]    register_address2;
    logic             clear_req;
    logic [WIDTH-1:0] register_data1;
    logic [WIDTH-1:0] register_data2;
    logic             busy;

    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    regfile_param_2r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock_reg         (clock_reg),
        .reset             (reset),
        .write_enable      (write_enable),
        .write_address     (write_address),
        .write_data        (write_data),
        .register_address1 (register_address1),
        .register_address2 (register_address2),
        .clear_req         (clear_req),
        .register_data1    (register_data1),
        .register_data2    (register_data2),
        .busy              (busy)
    );

    always #5 clock_reg = ~clock_reg;

    always @(posedge clock_reg) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every expectation that falls due after this edge.
    always @(negedge clock_reg) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_RD1:   act = register_data1;
                K_RD2:   act = register_data2;
                default: act = {7'b0, busy};
            endcase
            if (e.due < cyc) begin
                check({e.name, " (stale)"}, 8'hxx, e.val);
            end else begin
                check(e.name, act, e.val);
            end
        end
    end

    task automatic expect_out(input int kind, input logic [7:0] v, input string n);
        exp_t e;
        e.due  = cyc + 1;
        e.kind = kind;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic drive(input logic we, input int wa, input logic [7:0] wd,
                         input int a1, input int a2, input logic clr);
        write_enable      = we;
        write_address     = AW'(wa);
        write_data        = wd;
        register_address1 = AW'(a1);
        register_address2 = AW'(a2);
        clear_req         = clr;
    endtask

    task automatic tick();
        @(posedge clock_reg);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 0, 8'h00, 0, 0, 1'b0);
        tick();
        expect_out(K_BUSY, 8'h00, "reset busy");
        expect_out(K_RD1, 8'h00, "reset rd1");
        expect_out(K_RD2, 8'h00, "reset rd2");
        tick();
        reset = 1'b1;

        // All addresses read zero after reset.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 0, 8'h00, i, DEPTH - 1 - i, 1'b0);
            expect_out(K_RD1, 8'h00, $sformatf("post-reset rd1 a%0d", i));
            expect_out(K_RD2, 8'h00, $sformatf("post-reset rd2 a%0d", DEPTH - 1 - i));
            tick();
        end
        expect_out(K_BUSY, 8'h00, "post-reset busy");
        tick();

        // Plain write then read.
        drive(1'b1, 3, 8'hA5, 0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 8'h00, 3, 0, 1'b0);
        expect_out(K_RD1, 8'hA5, "read a3");
        tick();

        // Write to register 0 is discarded and never bypassed.
        drive(1'b1, 0, 8'h77, 0, 0, 1'b0);
        expect_out(K_RD2, 8'h00, "r0 write no bypass");
        tick();
        drive(1'b0, 0, 8'h00, 3, 0, 1'b0);
        expect_out(K_RD2, 8'h00, "r0 reads zero");
        expect_out(K_RD1, 8'hA5, "a3 still A5");
        tick();

        // Write-first bypass on both ports.
        drive(1'b1, 5, 8'h11, 0, 0, 1'b0);
        tick();
        drive(1'b1, 5, 8'h3C, 5, 5, 1'b0);
        expect_out(K_RD1, 8'h3C, "bypass rd1");
        expect_out(K_RD2, 8'h3C, "bypass rd2");
        tick();
        drive(1'b0, 0, 8'h00, 5, 3, 1'b0);
        expect_out(K_RD1, 8'h3C, "a5 after bypass");
        expect_out(K_RD2, 8'hA5, "a3 independent");
        tick();

        // Fill 1..15 with 0x10+i.
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b1, i, 8'(8'h10 + i), 0, 0, 1'b0);
            tick();
        end
        drive(1'b0, 0, 8'h00, 7, 15, 1'b0);
        expect_out(K_RD1, 8'h17, "fill a7");
        expect_out(K_RD2, 8'h1F, "fill a15");
        tick();

        // Soft clear: read on the accepting edge is still normal.
        drive(1'b0, 0, 8'h00, 3, 15, 1'b1);
        expect_out(K_BUSY, 8'h01, "sweep busy k0");
        expect_out(K_RD1, 8'h13, "rd on clear edge");
        tick();
        for (int k = 1; k <= 15; k++) begin
            // Mid-sweep writes and clear requests must be ignored.
            drive(k == 10, 2, 8'h99, 15, 2, (k == 7));
            expect_out(K_BUSY, (k <= 14) ? 8'h01 : 8'h00, $sformatf("sweep busy k%0d", k));
            expect_out(K_RD1, 8'h00, $sformatf("sweep rd1 k%0d", k));
            expect_out(K_RD2, 8'h00, $sformatf("sweep rd2 k%0d", k));
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 0, 8'h00, i, DEPTH - 1 - i, 1'b0);
            expect_out(K_RD1, 8'h00, $sformatf("cleared rd1 a%0d", i));
            expect_out(K_RD2, 8'h00, $sformatf("cleared rd2 a%0d", DEPTH - 1 - i));
            expect_out(K_BUSY, 8'h00, "idle after sweep");
            tick();
        end

        // Write and clear on the same edge: write lands, then is swept.
        drive(1'b1, 2, 8'hFF, 0, 0, 1'b1);
        expect_out(K_BUSY, 8'h01, "clr+wr busy");
        tick();
        for (int k = 1; k <= 15; k++) begin
            drive(1'b0, 0, 8'h00, 0, 0, 1'b0);
            expect_out(K_BUSY, (k <= 14) ? 8'h01 : 8'h00, $sformatf("clr+wr busy k%0d", k));
            tick();
        end
        drive(1'b0, 0, 8'h00, 2, 0, 1'b0);
        expect_out(K_RD1, 8'h00, "clr+wr a2 zero");
        tick();

        // clear_req held: back-to-back sweeps with one idle cycle between.
        for (int k = 0; k <= 31; k++) begin
            drive(1'b0, 0, 8'h00, 0, 0, (k <= 16));
            expect_out(K_BUSY, (k == 15 || k == 31) ? 8'h00 : 8'h01,
                       $sformatf("held clr busy k%0d", k));
            tick();
        end

        // Reset in the 6th busy cycle aborts the sweep.
        drive(1'b1, 9, 8'h42, 0, 0, 1'b0);
        tick();
        drive(1'b0, 0, 8'h00, 9, 0, 1'b1);
        expect_out(K_BUSY, 8'h01, "pre-abort busy k0");
        expect_out(K_RD1, 8'h42, "pre-abort a9");
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 0, 8'h00, 0, 0, 1'b0);
            expect_out(K_BUSY, 8'h01, $sformatf("pre-abort busy k%0d", k));
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 0, 8'h00, 9, 0, 1'b0);
        expect_out(K_BUSY, 8'h00, "abort busy");
        expect_out(K_RD1, 8'h00, "abort rd1");
        tick();
        reset = 1'b1;
        drive(1'b1, 9, 8'h5A, 9, 0, 1'b0);
        expect_out(K_BUSY, 8'h00, "after abort busy");
        expect_out(K_RD1, 8'h5A, "after abort bypass");
        tick();
        drive(1'b1, 8, 8'h66, 9, 8, 1'b0);
        expect_out(K_RD1, 8'h5A, "after abort a9");
        expect_out(K_RD2, 8'h66, "after abort a8 bypass");
        tick();
        drive(1'b0, 0, 8'h00, 8, 9, 1'b0);
        expect_out(K_RD1, 8'h66, "after abort a8");
        expect_out(K_RD2, 8'h5A, "after abort a9 rd2");
        tick();

        tick();
        tick();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
